// File: rtl/watchdog_pkg.sv
// Shared definitions for the watchdog datapath.
// Holds the divider FSM state type and the default Q-format constants
// used by fx_div_seq and its callers.
package watchdog_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_DIV   = 3'd2,
    S_SIGN  = 3'd3,
    S_DONE  = 3'd4
  } st_div_t;

  localparam int DEF_W = 32;
  localparam int DEF_F = 16;

  // Q16.16 reference points for the default word
  localparam logic [DEF_W-1:0] QF_ONE = DEF_W'(1) << DEF_F;
  localparam logic [DEF_W-1:0] QF_MAX = {1'b0, {(DEF_W-1){1'b1}}};
  localparam logic [DEF_W-1:0] QF_MIN = {1'b1, {(DEF_W-1){1'b0}}};

endpackage

// File: rtl/fx_div_step.sv
// Single restoring division step (combinational).
// Ports:
//   rem_in  - partial remainder before the step (always < divisor)
//   bit_in  - next dividend bit shifted in at the LSB
//   divisor - unsigned divisor magnitude
//   rem_out - partial remainder after the conditional subtract
//   q_bit   - quotient bit produced by this step
module fx_div_step #(
  parameter int RW = 48,
  parameter int DW = 32
) (
  input  logic [RW-1:0] rem_in,
  input  logic          bit_in,
  input  logic [DW-1:0] divisor,
  output logic [RW-1:0] rem_out,
  output logic          q_bit
);

  logic [RW:0]   shifted;
  logic [RW-1:0] div_lo;

  // One extra bit on the compare so a divisor of 2^(DW-1) cannot wrap.
  assign shifted = {rem_in, bit_in};
  assign div_lo  = RW'(divisor);
  assign q_bit   = (shifted >= {1'b0, div_lo});
  // The true difference is below the divisor, so dropping the top bit is exact.
  assign rem_out = q_bit ? (shifted[RW-1:0] - div_lo) : shifted[RW-1:0];

endmodule

// File: rtl/fx_div_seq.sv
// Sequential signed fixed-point divider, quot = num / den in Q(W-F).F.
// Restoring long division, one quotient bit per clock, truncating toward
// zero and saturating to the signed W-bit range.
// Ports:
//   clk, rst_n         - clock, synchronous active-low reset
//   start_calc         - request, accepted only when idle
//   num_in, den_in     - signed operands, latched on acceptance
//   busy               - high whenever not idle
//   done               - one-cycle completion pulse
//   quot_out           - registered quotient, held until the next result
//   invalid            - divide by zero, valid with done
//   sat                - result saturated, valid with done
module fx_div_seq
  import watchdog_pkg::*;
#(
  parameter int W = DEF_W,
  parameter int F = DEF_F
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start_calc,
  input  logic [W-1:0] num_in,
  input  logic [W-1:0] den_in,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] quot_out,
  output logic         invalid,
  output logic         sat
);

  localparam int QW = W + F;
  localparam int CW = $clog2(W + F + 1);

  localparam logic [QW-1:0] POS_LIM = (QW'(1) << (W - 1)) - QW'(1);
  localparam logic [QW-1:0] NEG_LIM = QW'(1) << (W - 1);
  localparam logic [W-1:0]  RES_MAX = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0]  RES_MIN = {1'b1, {(W-1){1'b0}}};

  // Magnitude of a two's complement word; -2^(W-1) maps to 2^(W-1).
  function automatic logic [W-1:0] mag(input logic [W-1:0] v);
    return v[W-1] ? -v : v;
  endfunction

  // Returns {sat, result} from the unsigned quotient and result sign.
  function automatic logic [W:0] sat_result(input logic neg, input logic [QW-1:0] q);
    if (!neg && (q > POS_LIM)) return {1'b1, RES_MAX};
    if (neg && (q > NEG_LIM))  return {1'b1, RES_MIN};
    return {1'b0, neg ? -q[W-1:0] : q[W-1:0]};
  endfunction

  st_div_t       state_q, state_d;
  logic [W-1:0]  num_q, num_d;
  logic [W-1:0]  den_q, den_d;
  logic [W-1:0]  dmag_q, dmag_d;
  logic          sign_q, sign_d;
  logic [QW-1:0] dvd_q, dvd_d;
  logic [QW-1:0] rem_q, rem_d;
  logic [QW-1:0] quo_q, quo_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  quot_q, quot_d;
  logic          inv_q, inv_d;
  logic          sat_q, sat_d;

  logic [QW-1:0] step_rem;
  logic          step_bit;
  logic [W:0]    fin;

  fx_div_step #(.RW(QW), .DW(W)) u_step (
    .rem_in  (rem_q),
    .bit_in  (dvd_q[QW-1]),
    .divisor (dmag_q),
    .rem_out (step_rem),
    .q_bit   (step_bit)
  );

  assign fin = sat_result(sign_q, quo_q);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      num_q   <= '0;
      den_q   <= '0;
      dmag_q  <= '0;
      sign_q  <= 1'b0;
      dvd_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      inv_q   <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      num_q   <= num_d;
      den_q   <= den_d;
      dmag_q  <= dmag_d;
      sign_q  <= sign_d;
      dvd_q   <= dvd_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      inv_q   <= inv_d;
      sat_q   <= sat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    num_d   = num_q;
    den_d   = den_q;
    dmag_d  = dmag_q;
    sign_d  = sign_q;
    dvd_d   = dvd_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    inv_d   = inv_q;
    sat_d   = sat_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_calc) begin
          num_d   = num_in;
          den_d   = den_in;
          inv_d   = 1'b0;
          sat_d   = 1'b0;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (den_q == '0) begin
          quot_d  = '0;
          inv_d   = 1'b1;
          sat_d   = 1'b0;
          state_d = S_DONE;
        end else begin
          sign_d  = num_q[W-1] ^ den_q[W-1];
          dmag_d  = mag(den_q);
          dvd_d   = {mag(num_q), {F{1'b0}}};
          rem_d   = '0;
          quo_d   = '0;
          cnt_d   = '0;
          state_d = S_DIV;
        end
      end
      S_DIV: begin
        rem_d = step_rem;
        quo_d = {quo_q[QW-2:0], step_bit};
        dvd_d = dvd_q << 1;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(QW - 1)) state_d = S_SIGN;
      end
      S_SIGN: begin
        sat_d   = fin[W];
        quot_d  = fin[W-1:0];
        state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);
  assign quot_out = quot_q;
  assign invalid  = inv_q;
  assign sat      = sat_q;

endmodule

// File: tb/tb_fx_div_seq.sv
module tb_fx_div_seq;

  localparam int W = 32;
  localparam int F = 16;
  localparam int LAT_NORM = W + F + 3;
  localparam int LAT_ZERO = 2;
  localparam int TMO = 200;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start_calc = 1'b0;
  logic [W-1:0] num_in = '0;
  logic [W-1:0] den_in = '0;
  logic         busy, done, invalid, sat;
  logic [W-1:0] quot_out;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fx_div_seq #(.W(W), .F(F)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_calc (start_calc),
    .num_in     (num_in),
    .den_in     (den_in),
    .busy       (busy),
    .done       (done),
    .quot_out   (quot_out),
    .invalid    (invalid),
    .sat        (sat)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Real-valued quotient scaled by 2^F, truncated toward zero, clamped.
  function automatic void model(input logic [W-1:0] n, input logic [W-1:0] d,
                                output logic [W-1:0] q, output logic inv, output logic s);
    longint nn, dd, qq;
    nn = longint'($signed(n));
    dd = longint'($signed(d));
    inv = 1'b0;
    s = 1'b0;
    if (dd == 0) begin
      q = '0;
      inv = 1'b1;
    end else begin
      qq = (nn * (64'sd1 <<< F)) / dd;
      if (qq > 64'sd2147483647) begin
        q = 32'h7FFF_FFFF;
        s = 1'b1;
      end else if (qq < -64'sd2147483648) begin
        q = 32'h8000_0000;
        s = 1'b1;
      end else begin
        q = qq[W-1:0];
      end
    end
  endfunction

  // noise=1 re-pulses start with other operands during cycles 5..20.
  task automatic run_div(input string tag, input logic [W-1:0] n, input logic [W-1:0] d,
                         input bit noise);
    logic [W-1:0] eq;
    logic         einv, esat;
    int           cyc;
    bit           busy_ok;
    model(n, d, eq, einv, esat);
    @(negedge clk);
    chk({tag, ".idle"}, 64'(busy), 64'd0);
    start_calc = 1'b1;
    num_in = n;
    den_in = d;
    @(negedge clk);
    cyc = 1;
    start_calc = 1'b0;
    num_in = $urandom;
    den_in = $urandom;
    chk({tag, ".flags_clr"}, 64'({invalid, sat}), 64'd0);
    busy_ok = 1'b1;
    while (!done && cyc < TMO) begin
      if (!busy) busy_ok = 1'b0;
      start_calc = noise && (cyc >= 4) && (cyc < 20);
      if (start_calc) begin
        num_in = $urandom;
        den_in = $urandom_range(1, 1000);
      end
      @(negedge clk);
      cyc++;
    end
    start_calc = 1'b0;
    if (!done) begin
      chk({tag, ".timeout"}, 64'(cyc), 64'(einv ? LAT_ZERO : LAT_NORM));
    end else begin
      chk({tag, ".latency"}, 64'(cyc), 64'(einv ? LAT_ZERO : LAT_NORM));
      chk({tag, ".quot"}, 64'(quot_out), 64'(eq));
      chk({tag, ".invalid"}, 64'(invalid), 64'(einv));
      chk({tag, ".sat"}, 64'(sat), 64'(esat));
      if (noise) chk({tag, ".busy_held"}, 64'(busy_ok), 64'd1);
    end
  endtask

  initial begin
    int cyc;
    bit saw_done;
    logic [W-1:0] rn, rd;
    repeat (3) @(negedge clk);
    chk("rst.busy", 64'(busy), 64'd0);
    chk("rst.done", 64'(done), 64'd0);
    chk("rst.quot", 64'(quot_out), 64'd0);
    chk("rst.invalid", 64'(invalid), 64'd0);
    chk("rst.sat", 64'(sat), 64'd0);
    rst_n = 1'b1;

    run_div("three_by_two", 32'h0003_0000, 32'h0002_0000, 1'b0);
    run_div("neg_quarter", 32'hFFFF_0000, 32'h0004_0000, 1'b0);
    run_div("third", 32'h0001_0000, 32'h0003_0000, 1'b0);
    run_div("div_zero", 32'h0005_0000, 32'h0000_0000, 1'b0);
    run_div("after_zero", 32'h0002_0000, 32'h0001_0000, 1'b0);
    run_div("sat_pos", 32'h7FFF_0000, 32'h0000_0100, 1'b0);
    run_div("sat_minneg", 32'h8000_0000, 32'hFFFF_0000, 1'b0);
    run_div("sat_neg", 32'h7FFF_0000, 32'hFFFF_FF00, 1'b0);
    run_div("exact_min", 32'h8000_0000, 32'h0001_0000, 1'b0);
    run_div("min_by_min", 32'h8000_0000, 32'h8000_0000, 1'b0);
    run_div("num_zero", 32'h0000_0000, 32'hFFF3_0000, 1'b0);
    run_div("neg_trunc", 32'hFFFF_0000, 32'h0003_0000, 1'b0);
    run_div("ignore_start", 32'h0007_0000, 32'hFFFE_0000, 1'b1);

    // Reset in the middle of the division loop.
    @(negedge clk);
    start_calc = 1'b1;
    num_in = 32'h0009_0000;
    den_in = 32'h0002_0000;
    @(negedge clk);
    start_calc = 1'b0;
    repeat (19) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst.busy", 64'(busy), 64'd0);
    chk("midrst.done", 64'(done), 64'd0);
    chk("midrst.quot", 64'(quot_out), 64'd0);
    saw_done = 1'b0;
    for (cyc = 0; cyc < 60; cyc++) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    chk("midrst.no_done", 64'(saw_done), 64'd0);
    run_div("post_rst", 32'h0009_0000, 32'h0002_0000, 1'b0);

    for (int i = 0; i < 30; i++) begin
      rn = $urandom;
      case (i % 4)
        0: rd = $urandom;
        1: rd = 32'($urandom_range(1, 65535));
        2: rd = -32'($urandom_range(1, 65535));
        default: rd = ($urandom_range(0, 9) == 0) ? 32'h0 : {$urandom_range(0, 65535), 16'h0};
      endcase
      if (i % 5 == 0) rn = rn >>> $urandom_range(8, 24);
      run_div("rand", rn, rd, (i % 7) == 3);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
